// File: rtl/bram_port_rmw_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bram_port_rmw_arbiter
// Function : Round-robin sharing of one BRAM port; bit write mask in logic
// Revision : 1.0  initial release
// ============================================================================
module bram_port_rmw_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 12,
  parameter int DW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [NREQ*AW-1:0] req_a_i,
  input  logic [NREQ*DW-1:0] req_d_i,
  input  logic [NREQ-1:0]    req_we_i,
  input  logic [NREQ*DW-1:0] req_wem_i,
  output logic [NREQ-1:0]    rsp_valid_o,
  output logic [DW-1:0]      rsp_data_o,
  output logic [AW-1:0]      mem_a_o,
  output logic [DW-1:0]      mem_d_o,
  output logic             mem_we_o,
  output logic             mem_ce_o,
  input  logic [DW-1:0]      mem_q_i
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RMW_RD = 2'd1;
  localparam logic [1:0] S_RMW_WR = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           mem_ce_q, mem_ce_d, mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_a_q, mem_a_d;
  logic [DW-1:0]  mem_d_q, mem_d_d;
  logic [AW-1:0]  rmw_a_q, rmw_a_d;
  logic [DW-1:0]  rmw_dat_q, rmw_dat_d, rmw_wem_q, rmw_wem_d;
  logic [IDW-1:0] rmw_id_q, rmw_id_d;
  logic           p1_valid_q, p1_valid_d, p1_useq_q, p1_useq_d;
  logic [IDW-1:0] p1_id_q, p1_id_d;
  logic [DW-1:0]  p1_data_q, p1_data_d;
  logic           s2_valid_q, s2_valid_d, s2_useq_q, s2_useq_d;
  logic [IDW-1:0] s2_id_q, s2_id_d;
  logic [DW-1:0]  s2_data_q, s2_data_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            found;
  int              idx;
  logic [AW-1:0]   sel_a;
  logic [DW-1:0]   sel_d, sel_wem, merged;
  logic            sel_we, is_full, is_rmw;

  // Grant only depends on valid, state and pointer, never on the write fields.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (state_q == S_IDLE) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr_q) + k) % NREQ;
        if (!found && req_valid_i[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = IDW'(idx);
        end
      end
    end
  end

  assign req_ready_o = grant;

  always_comb begin
    sel_a   = req_a_i[gidx*AW +: AW];
    sel_d   = req_d_i[gidx*DW +: DW];
    sel_wem = req_wem_i[gidx*DW +: DW];
    sel_we  = req_we_i[gidx];
    is_full = sel_we && (&sel_wem);
    is_rmw  = sel_we && (|sel_wem) && !(&sel_wem);
  end

  assign merged = (mem_q_i & ~rmw_wem_q) | (rmw_dat_q & rmw_wem_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mem_ce_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_a_d    = mem_a_q;
    mem_d_d    = mem_d_q;
    rmw_a_d    = rmw_a_q;
    rmw_dat_d  = rmw_dat_q;
    rmw_wem_d  = rmw_wem_q;
    rmw_id_d   = rmw_id_q;
    p1_valid_d = 1'b0;
    p1_useq_d  = p1_useq_q;
    p1_id_d    = p1_id_q;
    p1_data_d  = p1_data_q;
    s2_valid_d = p1_valid_q;
    s2_useq_d  = p1_useq_q;
    s2_id_d    = p1_id_q;
    s2_data_d  = p1_data_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          ptr_d    = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          mem_ce_d = 1'b1;
          mem_a_d  = sel_a;
          if (is_rmw) begin
            state_d   = S_RMW_RD;
            rmw_a_d   = sel_a;
            rmw_dat_d = sel_d;
            rmw_wem_d = sel_wem;
            rmw_id_d  = gidx;
          end else begin
            p1_valid_d = 1'b1;
            p1_id_d    = gidx;
            p1_useq_d  = !is_full;
            p1_data_d  = sel_d;
            if (is_full) begin
              mem_we_d = 1'b1;
              mem_d_d  = sel_d;
            end
          end
        end
      end
      S_RMW_RD: begin
        state_d  = S_RMW_WR;
        mem_ce_d = 1'b1;
        mem_we_d = 1'b1;
        mem_a_d  = rmw_a_q;
      end
      S_RMW_WR: begin
        // The pipeline stage is necessarily empty here: nothing was accepted
        // while the read half of this sequence was in flight.
        state_d    = S_IDLE;
        mem_d_d    = merged;
        s2_valid_d = 1'b1;
        s2_useq_d  = 1'b0;
        s2_id_d    = rmw_id_q;
        s2_data_d  = merged;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      rmw_a_q    <= '0;
      rmw_dat_q  <= '0;
      rmw_wem_q  <= '0;
      rmw_id_q   <= '0;
      p1_valid_q <= 1'b0;
      p1_useq_q  <= 1'b0;
      p1_id_q    <= '0;
      p1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_useq_q  <= 1'b0;
      s2_id_q    <= '0;
      s2_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mem_ce_q   <= mem_ce_d;
      mem_we_q   <= mem_we_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      rmw_a_q    <= rmw_a_d;
      rmw_dat_q  <= rmw_dat_d;
      rmw_wem_q  <= rmw_wem_d;
      rmw_id_q   <= rmw_id_d;
      p1_valid_q <= p1_valid_d;
      p1_useq_q  <= p1_useq_d;
      p1_id_q    <= p1_id_d;
      p1_data_q  <= p1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_useq_q  <= s2_useq_d;
      s2_id_q    <= s2_id_d;
      s2_data_q  <= s2_data_d;
    end
  end

  // Read data only exists on the BRAM Q port in the cycle it is consumed.
  assign mem_ce_o = mem_ce_q;
  assign mem_we_o = mem_we_q;
  assign mem_a_o  = mem_a_q;
  assign mem_d_o  = (state_q == S_RMW_WR) ? merged : mem_d_q;

  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (s2_valid_q) begin
      rsp_valid_o[s2_id_q] = 1'b1;
      rsp_data_o           = s2_useq_q ? mem_q_i : s2_data_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_rmw_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bram_port_rmw_arbiter
// Function : Directed vector table, reset-abort sequence and random traffic
// Revision : 1.0  initial release
// ============================================================================
module tb_bram_port_rmw_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [23:0] req_a;
  logic [7:0]  req_d, req_wem;
  logic [3:0]  rsp_data, mem_d, mem_q;
  logic [11:0] mem_a;
  logic        mem_we, mem_ce;

  always #5 clk = ~clk;

  bram_port_rmw_arbiter #(.NREQ(2), .AW(12), .DW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_d_i(req_d), .req_we_i(req_we), .req_wem_i(req_wem),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .mem_a_o(mem_a), .mem_d_o(mem_d), .mem_we_o(mem_we), .mem_ce_o(mem_ce),
    .mem_q_i(mem_q)
  );

  // BRAM model: read-first, Q registered one cycle after CE.
  bit         bram_init;
  logic [3:0] bram [0:4095];

  function automatic logic [3:0] init_val(input int i);
    case (i)
      'h123: return 4'h3;
      'h7FF: return 4'h5;
      'h010: return 4'h1;
      'h020: return 4'h2;
      'hFFF: return 4'h9;
      'h055: return 4'h0;
      default: return 4'((i * 5 + 3) & 15);
    endcase
  endfunction

  always @(posedge clk) begin
    if (!bram_init) begin
      for (int i = 0; i < 4096; i++) bram[i] <= init_val(i);
      bram_init <= 1'b1;
    end else if (mem_ce) begin
      if (mem_we) bram[mem_a] <= mem_d;
      mem_q <= bram[mem_a];
    end
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  v;
    logic [11:0] a0, a1;
    logic [3:0]  d0, d1;
    logic [1:0]  we;
    logic [3:0]  wem0, wem1;
    logic [1:0]  rdy;
    logic        ce, wr;
    logic [11:0] ma;
    logic [3:0]  md;
    logic [1:0]  rv;
    logic [3:0]  rd;
  } vec_t;

  vec_t vt[$];

  task automatic addv(input logic [1:0] v,
                      input logic [11:0] a0, input logic [3:0] d0, input logic we0, input logic [3:0] wem0,
                      input logic [11:0] a1, input logic [3:0] d1, input logic we1, input logic [3:0] wem1,
                      input logic [1:0] rdy, input logic ce, input logic wr, input logic [11:0] ma,
                      input logic [3:0] md, input logic [1:0] rv, input logic [3:0] rd);
    vec_t e;
    e.v = v; e.a0 = a0; e.d0 = d0; e.a1 = a1; e.d1 = d1; e.we = {we1, we0};
    e.wem0 = wem0; e.wem1 = wem1; e.rdy = rdy; e.ce = ce; e.wr = wr;
    e.ma = ma; e.md = md; e.rv = rv; e.rd = rd;
    vt.push_back(e);
  endtask

  task automatic drive(input logic [1:0] v, input logic [11:0] a0, input logic [3:0] d0,
                       input logic we0, input logic [3:0] wem0, input logic [11:0] a1,
                       input logic [3:0] d1, input logic we1, input logic [3:0] wem1);
    req_valid = v;
    req_a     = {a1, a0};
    req_d     = {d1, d0};
    req_we    = {we1, we0};
    req_wem   = {wem1, wem0};
  endtask

  typedef struct { int id; logic [3:0] data; } exp_t;
  exp_t       sb[$];
  logic [3:0] refm [0:4095];

  initial begin
    bit ok;
    int n_acc, n_rsp, multi;
    exp_t e;
    logic [1:0] acc;
    int g;
    logic [11:0] ra;
    logic [3:0] rdv, rwem;

    rst_n = 1'b0;
    drive(2'b00, 12'h0, 4'h0, 1'b0, 4'h0, 12'h0, 4'h0, 1'b0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, mem_ce, mem_we, mem_a, mem_d, rsp_valid, rsp_data} != '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b ce=%b we=%b a=%h d=%h rv=%b rd=%h, need all zero",
               req_ready, mem_ce, mem_we, mem_a, mem_d, rsp_valid, rsp_data);
    end
    rst_n = 1'b1;

    //    v      a0     d0   we wem0  a1     d1   we wem1  rdy    ce wr ma     md    rv     rd
    addv(2'b01, 12'h123, 4'hA, 1, 4'hF, 12'h000, 4'h0, 0, 4'h0, 2'b01, 0, 0, 12'h000, 4'h0, 2'b00, 4'h0);
    addv(2'b10, 12'h000, 4'h0, 0, 4'h0, 12'h123, 4'h0, 0, 4'h0, 2'b10, 1, 1, 12'h123, 4'hA, 2'b00, 4'h0);
    addv(2'b00, 12'h000, 4'h0, 0, 4'h0, 12'h000, 4'h0, 0, 4'h0, 2'b00, 1, 0, 12'h123, 4'h0, 2'b01, 4'hA);
    addv(2'b00, 12'h000, 4'h0, 0, 4'h0, 12'h000, 4'h0, 0, 4'h0, 2'b00, 0, 0, 12'h000, 4'h0, 2'b10, 4'hA);
    addv(2'b01, 12'h7FF, 4'hA, 1, 4'h3, 12'h000, 4'h0, 0, 4'h0, 2'b01, 0, 0, 12'h000, 4'h0, 2'b00, 4'h0);
    addv(2'b11, 12'h7FF, 4'hA, 1, 4'h3, 12'h7FF, 4'h0, 0, 4'h0, 2'b00, 1, 0, 12'h7FF, 4'h0, 2'b00, 4'h0);
    addv(2'b11, 12'h7FF, 4'hA, 1, 4'h3, 12'h7FF, 4'h0, 0, 4'h0, 2'b00, 1, 1, 12'h7FF, 4'h6, 2'b00, 4'h0);
    addv(2'b11, 12'h7FF, 4'hA, 1, 4'h3, 12'h7FF, 4'h0, 0, 4'h0, 2'b10, 0, 0, 12'h000, 4'h0, 2'b01, 4'h6);
    addv(2'b00, 12'h000, 4'h0, 0, 4'h0, 12'h000, 4'h0, 0, 4'h0, 2'b00, 1, 0, 12'h7FF, 4'h0, 2'b00, 4'h0);
    addv(2'b00, 12'h000, 4'h0, 0, 4'h0, 12'h000, 4'h0, 0, 4'h0, 2'b00, 0, 0, 12'h000, 4'h0, 2'b10, 4'h6);
    addv(2'b11, 12'h010, 4'h0, 0, 4'h0, 12'h020, 4'h0, 0, 4'h0, 2'b01, 0, 0, 12'h000, 4'h0, 2'b00, 4'h0);
    addv(2'b11, 12'h010, 4'h0, 0, 4'h0, 12'h020, 4'h0, 0, 4'h0, 2'b10, 1, 0, 12'h010, 4'h0, 2'b00, 4'h0);
    addv(2'b11, 12'h010, 4'h0, 0, 4'h0, 12'h020, 4'h0, 0, 4'h0, 2'b01, 1, 0, 12'h020, 4'h0, 2'b01, 4'h1);
    addv(2'b11, 12'h010, 4'h0, 0, 4'h0, 12'h020, 4'h0, 0, 4'h0, 2'b10, 1, 0, 12'h010, 4'h0, 2'b10, 4'h2);
    addv(2'b11, 12'h010, 4'h0, 0, 4'h0, 12'h020, 4'h0, 0, 4'h0, 2'b01, 1, 0, 12'h020, 4'h0, 2'b01, 4'h1);
    addv(2'b11, 12'h010, 4'h0, 0, 4'h0, 12'h020, 4'h0, 0, 4'h0, 2'b10, 1, 0, 12'h010, 4'h0, 2'b10, 4'h2);
    addv(2'b00, 12'h000, 4'h0, 0, 4'h0, 12'h000, 4'h0, 0, 4'h0, 2'b00, 1, 0, 12'h020, 4'h0, 2'b01, 4'h1);
    addv(2'b00, 12'h000, 4'h0, 0, 4'h0, 12'h000, 4'h0, 0, 4'h0, 2'b00, 0, 0, 12'h000, 4'h0, 2'b10, 4'h2);
    addv(2'b10, 12'h000, 4'h0, 0, 4'h0, 12'hFFF, 4'hF, 1, 4'h0, 2'b10, 0, 0, 12'h000, 4'h0, 2'b00, 4'h0);
    addv(2'b00, 12'h000, 4'h0, 0, 4'h0, 12'h000, 4'h0, 0, 4'h0, 2'b00, 1, 0, 12'hFFF, 4'h0, 2'b00, 4'h0);
    addv(2'b00, 12'h000, 4'h0, 0, 4'h0, 12'h000, 4'h0, 0, 4'h0, 2'b00, 0, 0, 12'h000, 4'h0, 2'b10, 4'h9);
    addv(2'b00, 12'h000, 4'h0, 0, 4'h0, 12'h000, 4'h0, 0, 4'h0, 2'b00, 0, 0, 12'h000, 4'h0, 2'b00, 4'h0);

    @(posedge clk); #1;
    foreach (vt[i]) begin
      drive(vt[i].v, vt[i].a0, vt[i].d0, vt[i].we[0], vt[i].wem0,
            vt[i].a1, vt[i].d1, vt[i].we[1], vt[i].wem1);
      @(negedge clk);
      ok = (req_ready == vt[i].rdy) && (mem_ce == vt[i].ce) && (mem_we == vt[i].wr) &&
           (rsp_valid == vt[i].rv);
      if (vt[i].ce && mem_a != vt[i].ma) ok = 1'b0;
      if (vt[i].wr && mem_d != vt[i].md) ok = 1'b0;
      if (vt[i].rv != 2'b00 && rsp_data != vt[i].rd) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec%0d: got rdy=%b ce=%b we=%b a=%h d=%h rv=%b rd=%h, need rdy=%b ce=%b we=%b a=%h d=%h rv=%b rd=%h",
                 i, req_ready, mem_ce, mem_we, mem_a, mem_d, rsp_valid, rsp_data,
                 vt[i].rdy, vt[i].ce, vt[i].wr, vt[i].ma, vt[i].md, vt[i].rv, vt[i].rd);
      end
      @(posedge clk); #1;
    end

    // Reset in the middle of an RMW must abort the write.
    drive(2'b01, 12'h055, 4'hF, 1'b1, 4'h1, 12'h0, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    checks++;
    if (req_ready != 2'b01) begin
      errors++;
      $display("FAIL rmw_accept: got rdy=%b, need 01", req_ready);
    end
    @(posedge clk); #1;
    drive(2'b00, 12'h0, 4'h0, 1'b0, 4'h0, 12'h0, 4'h0, 1'b0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, mem_ce, mem_we, mem_a, mem_d, rsp_valid, rsp_data} != '0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b ce=%b we=%b a=%h d=%h rv=%b rd=%h, need all zero",
               req_ready, mem_ce, mem_we, mem_a, mem_d, rsp_valid, rsp_data);
    end
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_we || mem_ce || rsp_valid != 2'b00) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_hold: got activity during reset, need none");
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(2'b11, 12'h055, 4'h0, 1'b0, 4'h0, 12'h055, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    checks++;
    if (req_ready != 2'b01) begin
      errors++;
      $display("FAIL tie_after_reset: got rdy=%b, need 01", req_ready);
    end
    @(posedge clk); #1;
    drive(2'b00, 12'h0, 4'h0, 1'b0, 4'h0, 12'h0, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid != 2'b01 || rsp_data != 4'h0) begin
      errors++;
      $display("FAIL aborted_rmw_data: got rv=%b rd=%h, need rv=01 rd=0", rsp_valid, rsp_data);
    end
    repeat (3) @(posedge clk);
    #1;

    // Random mixed traffic against a reference memory.
    for (int i = 0; i < 4096; i++) refm[i] = bram[i];
    n_acc = 0; n_rsp = 0; multi = 0;
    for (int c = 0; c < 460; c++) begin
      if (c < 400) begin
        req_valid = 2'($urandom_range(0, 3));
        for (int r = 0; r < 2; r++) begin
          req_a[r*12 +: 12] = 12'h200 + 12'($urandom_range(0, 7));
          req_d[r*4 +: 4]   = 4'($urandom_range(0, 15));
          req_we[r]         = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 3))
            0: req_wem[r*4 +: 4] = 4'h0;
            1: req_wem[r*4 +: 4] = 4'hF;
            default: req_wem[r*4 +: 4] = 4'($urandom_range(1, 14));
          endcase
        end
      end else begin
        req_valid = 2'b00;
      end
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        n_rsp++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rnd_rsp_unexpected: got rv=%b rd=%h, need no response", rsp_valid, rsp_data);
        end else begin
          e = sb.pop_front();
          if (rsp_valid != (2'b01 << e.id) || rsp_data != e.data) begin
            errors++;
            $display("FAIL rnd_rsp: got rv=%b rd=%h, need rv=%b rd=%h",
                     rsp_valid, rsp_data, 2'b01 << e.id, e.data);
          end
        end
      end
      acc = req_valid & req_ready;
      if (acc == 2'b11) multi++;
      if (acc != 2'b00) begin
        n_acc++;
        g    = acc[0] ? 0 : 1;
        ra   = req_a[g*12 +: 12];
        rdv  = req_d[g*4 +: 4];
        rwem = req_wem[g*4 +: 4];
        e.id = g;
        if (req_we[g] && rwem != 4'h0) refm[ra] = (refm[ra] & ~rwem) | (rdv & rwem);
        e.data = refm[ra];
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n_acc != n_rsp || sb.size() != 0 || multi != 0 || n_acc < 50) begin
      errors++;
      $display("FAIL rnd_counts: got accepts=%0d rsps=%0d pending=%0d double_grants=%0d, need equal counts (>=50), none pending, no double grants",
               n_acc, n_rsp, sb.size(), multi);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
